key_entry: RTL and testbench

//  Consumer of the keypad scanner's key-code stream (4-bit code + 1-cycle strobe).
//  - Turns repeated strobes from a held key into a single key press.
//  - Builds a right-aligned BCD number of up to MAX_DIGITS digits, with backspace and clear.
//  - On ENTER, converts the BCD to binary with a sequential multiply-by-10 loop.
//  - Hands the binary result to downstream logic with a 1-cycle valid pulse.

---
 rtl/key_entry.sv | 151 +++++++++++++++
 tb/tb_key_entry.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry.sv
// key_entry: turns keypad strobes into debounced presses, builds a BCD
// number with backspace/clear, and converts it to binary on enter.
//
// Ports:
//   clk, rst     system clock, async active-high reset
//   key_code     4-bit key code (0-9 digits, A bksp, B clear, F enter)
//   key_valid    1-cycle strobe, repeats while a key is held
//   digits_bcd   entry buffer, newest digit in nibble 0
//   digit_count  number of digits held
//   num_bin      last converted value
//   num_valid    1-cycle pulse when num_bin updates
//   busy         high while converting
//   overflow     1-cycle pulse when a digit is rejected (buffer full)
module key_entry #(
   parameter int MAX_DIGITS  = 3,
   parameter int RELEASE_CYC = 16384,
   localparam int BIN_W      = $clog2(10**MAX_DIGITS),
   localparam int CW         = $clog2(MAX_DIGITS+1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              key_code,
   input  logic                    key_valid,
   output logic [4*MAX_DIGITS-1:0] digits_bcd,
   output logic [CW-1:0]           digit_count,
   output logic [BIN_W-1:0]        num_bin,
   output logic                    num_valid,
   output logic                    busy,
   output logic                    overflow
);

   localparam int RW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
   localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
   localparam int SW = BIN_W + 4;

   localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYC-1);
   localparam logic [IW-1:0] IDX_TOP  = IW'(MAX_DIGITS-1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);

   localparam logic [0:0] ENTRY   = 1'b0;
   localparam logic [0:0] CONVERT = 1'b1;

   logic [0:0]       state;
   logic             held;
   logic [RW-1:0]    rel_cnt;
   logic [3:0]       last_code;
   logic [BIN_W-1:0] acc;
   logic [IW-1:0]    idx;

   logic             accept;
   logic             is_digit;
   logic             is_bs;
   logic             is_clr;
   logic             is_ent;
   logic [3:0]       nib;
   logic [BIN_W-1:0] acc_nx;

   // A strobe is a new press unless it repeats the key still held down.
   assign accept   = key_valid && (!held || key_code != last_code);
   assign is_digit = key_code <= 4'd9;
   assign is_bs    = key_code == 4'hA;
   assign is_clr   = key_code == 4'hB;
   assign is_ent   = key_code == 4'hF;

   // Walk the buffer from the most significant nibble down.
   assign nib    = digits_bcd[{idx, 2'b00} +: 4];
   assign acc_nx = BIN_W'(({4'b0000, acc} * SW'(10)) + SW'(nib));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ENTRY;
         held        <= 1'b0;
         rel_cnt     <= '0;
         last_code   <= 4'h0;
         acc         <= '0;
         idx         <= '0;
         digits_bcd  <= '0;
         digit_count <= '0;
         num_bin     <= '0;
         num_valid   <= 1'b0;
         busy        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         num_valid <= 1'b0;
         overflow  <= 1'b0;

         if (key_valid) begin
            rel_cnt <= '0;
            if (accept) begin
               held      <= 1'b1;
               last_code <= key_code;
            end
         end else if (held) begin
            if (rel_cnt == REL_LAST) begin
               held    <= 1'b0;
               rel_cnt <= '0;
            end else begin
               rel_cnt <= rel_cnt + RW'(1);
            end
         end

         if (state == ENTRY) begin
            if (accept) begin
               unique case (1'b1)
                  is_digit: begin
                     if (digit_count < CNT_MAX) begin
                        digits_bcd      <= digits_bcd << 4;
                        digits_bcd[3:0] <= key_code;
                        digit_count     <= digit_count + CW'(1);
                     end else begin
                        overflow <= 1'b1;
                     end
                  end
                  is_bs: begin
                     if (digit_count != '0) begin
                        digits_bcd  <= digits_bcd >> 4;
                        digit_count <= digit_count - CW'(1);
                     end
                  end
                  is_clr: begin
                     digits_bcd  <= '0;
                     digit_count <= '0;
                  end
                  is_ent: begin
                     if (digit_count != '0) begin
                        state <= CONVERT;
                        busy  <= 1'b1;
                        acc   <= '0;
                        idx   <= IDX_TOP;
                     end
                  end
                  default: ;
               endcase
            end
         end else begin
            // Unused upper nibbles are zero, so a fixed-length loop is exact.
            acc <= acc_nx;
            idx <= idx - IW'(1);
            if (idx == '0) begin
               num_bin     <= acc_nx;
               num_valid   <= 1'b1;
               digits_bcd  <= '0;
               digit_count <= '0;
               busy        <= 1'b0;
               state       <= ENTRY;
            end
         end
      end
   end

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry (MAX_DIGITS=3, RELEASE_CYC=16).
// Table vectors, directed corner sequences and random keys vs a model.
module tb_key_entry;

   localparam int REL = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        kv  = 1'b0;
   logic [3:0]  kc  = 4'h0;
   logic [11:0] digits_bcd;
   logic [1:0]  digit_count;
   logic [9:0]  num_bin;
   logic        num_valid;
   logic        busy;
   logic        overflow;
   logic [26:0] obs;

   always #5 clk = ~clk;

   key_entry #(.MAX_DIGITS(3), .RELEASE_CYC(REL)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_code    (kc),
      .key_valid   (kv),
      .digits_bcd  (digits_bcd),
      .digit_count (digit_count),
      .num_bin     (num_bin),
      .num_valid   (num_valid),
      .busy        (busy),
      .overflow    (overflow)
   );

   assign obs = {digits_bcd, digit_count, num_bin, num_valid, busy, overflow};

   int n_chk = 0;
   int n_pass = 0;
   int nv_seen = 0;
   int ov_seen = 0;
   int busy_seen = 0;

   // Reference model: press history by strobe time, digits as a queue.
   int         t = 0;
   int         last_t = 0;
   bit         ever = 1'b0;
   logic [3:0] last_code = 4'h0;
   logic [3:0] q[$];
   int         conv_left = 0;
   int         conv_val = 0;
   logic [9:0] m_nb = '0;
   logic       m_nv = 1'b0;
   logic       m_ovf = 1'b0;
   logic       m_busy = 1'b0;

   typedef struct {
      logic [3:0]  code;
      logic [11:0] bcd;
      logic [1:0]  cnt;
      int          ovf;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (t=%0d)", nm, act, exp, t);
   endtask

   function automatic logic [11:0] pack();
      logic [11:0] r = '0;
      for (int i = 0; i < q.size(); i++)
         r[4*i +: 4] = q[q.size()-1-i];
      return r;
   endfunction

   task automatic model_reset();
      ever = 1'b0;
      q.delete();
      conv_left = 0;
      m_nb = '0;
      m_nv = 1'b0;
      m_ovf = 1'b0;
      m_busy = 1'b0;
   endtask

   task automatic model_edge(input logic v, input logic [3:0] c);
      bit was_busy;
      bit acc;
      t++;
      was_busy = conv_left > 0;
      acc = v && (!ever || c != last_code || (t - last_t) > REL);
      if (v) begin
         ever = 1'b1;
         last_code = c;
         last_t = t;
      end
      m_ovf = 1'b0;
      m_nv = 1'b0;
      if (was_busy) begin
         conv_left--;
         if (conv_left == 0) begin
            m_nb = 10'(conv_val);
            m_nv = 1'b1;
            q.delete();
         end
      end else if (acc) begin
         if (c <= 4'd9) begin
            if (q.size() < 3) q.push_back(c);
            else m_ovf = 1'b1;
         end else if (c == 4'hA) begin
            if (q.size() > 0) void'(q.pop_back());
         end else if (c == 4'hB) begin
            q.delete();
         end else if (c == 4'hF && q.size() > 0) begin
            conv_val = 0;
            foreach (q[i]) conv_val = conv_val * 10 + int'(q[i]);
            conv_left = 3;
         end
      end
      m_busy = conv_left > 0;
   endtask

   task automatic cyc(input logic v, input logic [3:0] c);
      logic [26:0] exp;
      @(negedge clk);
      kv = v;
      kc = c;
      @(posedge clk);
      #1;
      model_edge(v, c);
      exp = {pack(), 2'(q.size()), m_nb, m_nv, m_busy, m_ovf};
      chk("model", 32'(obs), 32'(exp));
      if (num_valid) nv_seen++;
      if (overflow) ov_seen++;
      if (busy) busy_seen++;
   endtask

   task automatic press(input logic [3:0] c);
      cyc(1'b1, c);
      repeat (20) cyc(1'b0, 4'h0);
   endtask

   task automatic enter_chk(input string nm, input logic [9:0] v);
      nv_seen = 0;
      busy_seen = 0;
      cyc(1'b1, 4'hF);
      repeat (25) cyc(1'b0, 4'h0);
      chk({nm, "_busy_cyc"}, 32'(busy_seen), 32'd3);
      chk({nm, "_nv_pulses"}, 32'(nv_seen), 32'd1);
      chk({nm, "_num_bin"}, 32'(num_bin), 32'(v));
      chk({nm, "_count"}, 32'(digit_count), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      kv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 32'(obs), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      tbl[0]  = '{4'h1, 12'h001, 2'd1, 0};
      tbl[1]  = '{4'h2, 12'h012, 2'd2, 0};
      tbl[2]  = '{4'h3, 12'h123, 2'd3, 0};
      tbl[3]  = '{4'h4, 12'h123, 2'd3, 1};
      tbl[4]  = '{4'hA, 12'h012, 2'd2, 0};
      tbl[5]  = '{4'hA, 12'h001, 2'd1, 0};
      tbl[6]  = '{4'hA, 12'h000, 2'd0, 0};
      tbl[7]  = '{4'hA, 12'h000, 2'd0, 0};
      tbl[8]  = '{4'h9, 12'h009, 2'd1, 0};
      tbl[9]  = '{4'hB, 12'h000, 2'd0, 0};
      tbl[10] = '{4'hC, 12'h000, 2'd0, 0};
      tbl[11] = '{4'hD, 12'h000, 2'd0, 0};
      tbl[12] = '{4'hE, 12'h000, 2'd0, 0};
      tbl[13] = '{4'h5, 12'h005, 2'd1, 0};
      tbl[14] = '{4'hB, 12'h000, 2'd0, 0};

      do_reset();

      for (int i = 0; i < 15; i++) begin
         ov_seen = 0;
         press(tbl[i].code);
         chk($sformatf("tbl%0d_bcd", i), 32'(digits_bcd), 32'(tbl[i].bcd));
         chk($sformatf("tbl%0d_cnt", i), 32'(digit_count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_ovf", i), 32'(ov_seen), 32'(tbl[i].ovf));
      end

      // 1) 1,2,3 then enter
      press(4'h1);
      press(4'h2);
      press(4'h3);
      chk("t1_bcd", 32'(digits_bcd), 32'h123);
      enter_chk("t1", 10'd123);

      // 2) held 7 gives a single digit
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 4'h7);
         repeat (9) cyc(1'b0, 4'h0);
      end
      repeat (20) cyc(1'b0, 4'h0);
      chk("t2_cnt", 32'(digit_count), 32'd1);
      chk("t2_bcd", 32'(digits_bcd), 32'h007);
      press(4'h7);
      chk("t2_bcd2", 32'(digits_bcd), 32'h077);

      // 3) overflow then enter 999
      press(4'hB);
      press(4'h9);
      press(4'h9);
      press(4'h9);
      ov_seen = 0;
      press(4'h4);
      chk("t3_ovf", 32'(ov_seen), 32'd1);
      chk("t3_bcd", 32'(digits_bcd), 32'h999);
      enter_chk("t3", 10'd999);

      // 4) backspace, and enter after clear is ignored
      press(4'h4);
      press(4'h5);
      press(4'hA);
      press(4'h6);
      enter_chk("t4", 10'd46);
      press(4'h8);
      press(4'hB);
      nv_seen = 0;
      busy_seen = 0;
      cyc(1'b1, 4'hF);
      repeat (25) cyc(1'b0, 4'h0);
      chk("t4_empty_nv", 32'(nv_seen), 32'd0);
      chk("t4_empty_busy", 32'(busy_seen), 32'd0);

      // 5) key during convert is dropped and stays held
      press(4'h1);
      cyc(1'b1, 4'hF);
      cyc(1'b1, 4'h5);
      repeat (8) cyc(1'b0, 4'h0);
      cyc(1'b1, 4'h5);
      repeat (20) cyc(1'b0, 4'h0);
      chk("t5_cnt", 32'(digit_count), 32'd0);
      chk("t5_bcd", 32'(digits_bcd), 32'h000);
      chk("t5_num", 32'(num_bin), 32'd1);

      // 6) reset one cycle into convert
      press(4'h3);
      cyc(1'b1, 4'hF);
      cyc(1'b0, 4'h0);
      rst = 1'b1;
      #1;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_num", 32'(num_bin), 32'd0);
      chk("t6_all", 32'(obs), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      nv_seen = 0;
      repeat (25) cyc(1'b0, 4'h0);
      chk("t6_no_nv", 32'(nv_seen), 32'd0);
      press(4'h2);
      enter_chk("t6", 10'd2);

      // random keys against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic       v;
         logic [3:0] c;
         int         r;
         v = ($urandom_range(0, 5) == 0);
         r = $urandom_range(0, 19);
         if (r < 12)      c = 4'($urandom_range(0, 9));
         else if (r < 14) c = 4'hA;
         else if (r < 16) c = 4'hB;
         else if (r < 19) c = 4'hF;
         else             c = 4'($urandom_range(12, 14));
         cyc(v, c);
         if ($urandom_range(0, 30) == 0) repeat (18) cyc(1'b0, 4'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
